// File: rtl/ex_fwd_pkg.sv
// Shared constants and types for the execute-stage forwarding / hazard unit.
//   FWD_*     : per-operand forwarding select encodings
//   mc_state_e: multi-cycle sequencer states
//   DEF_*     : default datapath / register-address widths
package ex_fwd_pkg;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam int DEF_XLEN = 64;
  localparam int DEF_RA_W = 5;

  typedef enum logic {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_e;

endpackage

// File: rtl/fwd_operand_mux.sv
// Forwarding compare + mux for a single EX source operand.
//   rs, rdata           : operand register address and register-file value
//   ex_mem_*            : EX/MEM producer (regwrite, rd, ALU result)
//   mem_wb_*            : MEM/WB producer (regwrite, load flag, rd, ALU result, load data)
//   sel, data           : chosen source (FWD_*) and the forwarded value
// EX/MEM is the younger producer and wins over MEM/WB; x0 never forwards.
module fwd_operand_mux
  import ex_fwd_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int RA_W = DEF_RA_W
) (
  input  logic [RA_W-1:0] rs,
  input  logic [XLEN-1:0] rdata,
  input  logic            ex_mem_regwrite,
  input  logic [RA_W-1:0] ex_mem_rd,
  input  logic [XLEN-1:0] ex_mem_alu_result,
  input  logic            mem_wb_regwrite,
  input  logic            mem_wb_mem_to_reg,
  input  logic [RA_W-1:0] mem_wb_rd,
  input  logic [XLEN-1:0] mem_wb_alu_result,
  input  logic [XLEN-1:0] mem_wb_read_data,
  output logic [1:0]      sel,
  output logic [XLEN-1:0] data
);

  logic hit_exmem, hit_memwb;

  assign hit_exmem = ex_mem_regwrite && (ex_mem_rd != '0) && (ex_mem_rd == rs);
  assign hit_memwb = mem_wb_regwrite && (mem_wb_rd != '0) && (mem_wb_rd == rs);

  always_comb begin
    sel  = FWD_REG;
    data = rdata;
    if (hit_exmem) begin
      sel  = FWD_EXMEM;
      data = ex_mem_alu_result;
    end else if (hit_memwb) begin
      sel  = FWD_MEMWB;
      // loads in WB carry their value in read_data, not the address in alu_result
      data = mem_wb_mem_to_reg ? mem_wb_read_data : mem_wb_alu_result;
    end
  end

endmodule

// File: rtl/ex_fwd_hazard_unit.sv
// Execute-stage forwarding and hazard controller.
//   clk, reset          : clock, async active-low reset
//   id_ex_*             : instruction in EX (sources, regfile data, load/multicycle flags, rd)
//   if_id_rs(_used)     : sources of the instruction in ID, for load-use detection
//   ex_mem_*, mem_wb_*  : downstream producers for forwarding
//   flush               : kill from MEM; overrides every hold this cycle
//   fwd_sel, fwd_data   : per-operand forwarding result
//   pc_hold .. ex_mem_bubble : pipeline control
//   mc_busy, mc_done    : multi-cycle sequencer status
//   cnt_load_use, cnt_mc_stall : saturating stall counters
module ex_fwd_hazard_unit
  import ex_fwd_pkg::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int RA_W    = DEF_RA_W,
  parameter int NUM_SRC = 2,
  parameter int MC_LAT  = 4,
  parameter int CNT_W   = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_SRC*RA_W-1:0] id_ex_rs,
  input  logic [NUM_SRC*XLEN-1:0] id_ex_rdata,
  input  logic                    id_ex_valid,
  input  logic                    id_ex_mem_read,
  input  logic [RA_W-1:0]         id_ex_rd,
  input  logic                    id_ex_multicycle,
  input  logic [NUM_SRC*RA_W-1:0] if_id_rs,
  input  logic [NUM_SRC-1:0]      if_id_rs_used,
  input  logic                    ex_mem_regwrite,
  input  logic [RA_W-1:0]         ex_mem_rd,
  input  logic [XLEN-1:0]         ex_mem_alu_result,
  input  logic                    mem_wb_regwrite,
  input  logic                    mem_wb_mem_to_reg,
  input  logic [RA_W-1:0]         mem_wb_rd,
  input  logic [XLEN-1:0]         mem_wb_alu_result,
  input  logic [XLEN-1:0]         mem_wb_read_data,
  input  logic                    flush,
  output logic [NUM_SRC*2-1:0]    fwd_sel,
  output logic [NUM_SRC*XLEN-1:0] fwd_data,
  output logic                    pc_hold,
  output logic                    if_id_hold,
  output logic                    id_ex_hold,
  output logic                    id_ex_bubble,
  output logic                    ex_mem_bubble,
  output logic                    mc_busy,
  output logic                    mc_done,
  output logic [CNT_W-1:0]        cnt_load_use,
  output logic [CNT_W-1:0]        cnt_mc_stall
);

  // down-counter holds MC_LAT-2; never narrower than 3 bits
  localparam int MCW = ($clog2(MC_LAT) > 3) ? $clog2(MC_LAT) : 3;

  // ---------------- forwarding ----------------
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_op
    fwd_operand_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_mux (
      .rs                (id_ex_rs[i*RA_W +: RA_W]),
      .rdata             (id_ex_rdata[i*XLEN +: XLEN]),
      .ex_mem_regwrite   (ex_mem_regwrite),
      .ex_mem_rd         (ex_mem_rd),
      .ex_mem_alu_result (ex_mem_alu_result),
      .mem_wb_regwrite   (mem_wb_regwrite),
      .mem_wb_mem_to_reg (mem_wb_mem_to_reg),
      .mem_wb_rd         (mem_wb_rd),
      .mem_wb_alu_result (mem_wb_alu_result),
      .mem_wb_read_data  (mem_wb_read_data),
      .sel               (fwd_sel[i*2 +: 2]),
      .data              (fwd_data[i*XLEN +: XLEN])
    );
  end

  // ---------------- load-use ----------------
  logic [NUM_SRC-1:0] lu_hit;
  logic               lu, lu_stall;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lu
    assign lu_hit[i] = if_id_rs_used[i] && (if_id_rs[i*RA_W +: RA_W] == id_ex_rd);
  end

  assign lu = id_ex_valid && id_ex_mem_read && (id_ex_rd != '0) && (|lu_hit);

  // ---------------- multi-cycle sequencer ----------------
  mc_state_e      state, state_nxt;
  logic [MCW-1:0] cnt, cnt_nxt;
  logic           mc_start, mc_hold, mc_last;

  assign mc_start = id_ex_valid && id_ex_multicycle;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (flush) begin
      state_nxt = RUN;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        RUN: if (mc_start) begin
          state_nxt = MC_BUSY;
          cnt_nxt   = MCW'(MC_LAT - 2);
        end
        MC_BUSY: if (cnt != '0) cnt_nxt = cnt - MCW'(1);
                 else           state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  // the RUN entry cycle is itself a hold cycle, so an op spans MC_LAT-1 holds + done
  always_comb begin
    mc_hold = 1'b0;
    mc_last = 1'b0;
    if (!flush) begin
      unique case (state)
        RUN:     mc_hold = mc_start;
        MC_BUSY: if (cnt != '0) mc_hold = 1'b1;
                 else           mc_last = 1'b1;
        default: ;
      endcase
    end
  end

  // a multi-cycle hold freezes ID, so the load-use bubble waits until it drops
  assign lu_stall = lu && !mc_hold && !flush;

  // control outputs are forced low for the whole reset window
  assign pc_hold       = reset && (mc_hold || lu_stall);
  assign if_id_hold    = reset && (mc_hold || lu_stall);
  assign id_ex_hold    = reset && mc_hold;
  assign ex_mem_bubble = reset && mc_hold;
  assign id_ex_bubble  = reset && (flush || lu_stall);
  assign mc_busy       = reset && (state == MC_BUSY);
  assign mc_done       = reset && mc_last;

  // ---------------- saturating counters ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_load_use <= '0;
      cnt_mc_stall <= '0;
    end else begin
      if (lu_stall && (cnt_load_use != '1)) cnt_load_use <= cnt_load_use + CNT_W'(1);
      if (mc_hold  && (cnt_mc_stall != '1)) cnt_mc_stall <= cnt_mc_stall + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ex_fwd_hazard_unit.sv
module tb_ex_fwd_hazard_unit;
  localparam int XLEN = 64, RA_W = 5, NUM_SRC = 2, MC_LAT = 4, CNT_W = 4;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_SRC*RA_W-1:0] id_ex_rs;
  logic [NUM_SRC*XLEN-1:0] id_ex_rdata;
  logic                    id_ex_valid, id_ex_mem_read, id_ex_multicycle;
  logic [RA_W-1:0]         id_ex_rd;
  logic [NUM_SRC*RA_W-1:0] if_id_rs;
  logic [NUM_SRC-1:0]      if_id_rs_used;
  logic                    ex_mem_regwrite;
  logic [RA_W-1:0]         ex_mem_rd;
  logic [XLEN-1:0]         ex_mem_alu_result;
  logic                    mem_wb_regwrite, mem_wb_mem_to_reg;
  logic [RA_W-1:0]         mem_wb_rd;
  logic [XLEN-1:0]         mem_wb_alu_result, mem_wb_read_data;
  logic                    flush;
  logic [NUM_SRC*2-1:0]    fwd_sel;
  logic [NUM_SRC*XLEN-1:0] fwd_data;
  logic                    pc_hold, if_id_hold, id_ex_hold, id_ex_bubble, ex_mem_bubble;
  logic                    mc_busy, mc_done;
  logic [CNT_W-1:0]        cnt_load_use, cnt_mc_stall;

  always #5 clk = ~clk;

  ex_fwd_hazard_unit #(.XLEN(XLEN), .RA_W(RA_W), .NUM_SRC(NUM_SRC), .MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_ex_rs(id_ex_rs), .id_ex_rdata(id_ex_rdata), .id_ex_valid(id_ex_valid),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd), .id_ex_multicycle(id_ex_multicycle),
    .if_id_rs(if_id_rs), .if_id_rs_used(if_id_rs_used),
    .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_rd(ex_mem_rd), .ex_mem_alu_result(ex_mem_alu_result),
    .mem_wb_regwrite(mem_wb_regwrite), .mem_wb_mem_to_reg(mem_wb_mem_to_reg), .mem_wb_rd(mem_wb_rd),
    .mem_wb_alu_result(mem_wb_alu_result), .mem_wb_read_data(mem_wb_read_data),
    .flush(flush),
    .fwd_sel(fwd_sel), .fwd_data(fwd_data),
    .pc_hold(pc_hold), .if_id_hold(if_id_hold), .id_ex_hold(id_ex_hold),
    .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble),
    .mc_busy(mc_busy), .mc_done(mc_done),
    .cnt_load_use(cnt_load_use), .cnt_mc_stall(cnt_mc_stall)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // m_left = EX cycles still owed by the current multi-cycle op (0 = none)
  int m_left = 0, m_lu = 0, m_mc = 0;
  int n_left = 0, n_lu = 0, n_mc = 0;

  always @(negedge clk) begin : compare
    logic [1:0]      es;
    logic [XLEN-1:0] ed;
    logic [RA_W-1:0] r;
    bit lu, hold, done, busy, lus, rr;
    for (int i = 0; i < NUM_SRC; i++) begin
      r = id_ex_rs[i*RA_W +: RA_W];
      if (ex_mem_regwrite && ex_mem_rd != 0 && ex_mem_rd == r) begin
        es = 2'b10; ed = ex_mem_alu_result;
      end else if (mem_wb_regwrite && mem_wb_rd != 0 && mem_wb_rd == r) begin
        es = 2'b01; ed = mem_wb_mem_to_reg ? mem_wb_read_data : mem_wb_alu_result;
      end else begin
        es = 2'b00; ed = id_ex_rdata[i*XLEN +: XLEN];
      end
      chk($sformatf("m.fwd_sel%0d", i), 64'(fwd_sel[i*2 +: 2]), 64'(es));
      chk($sformatf("m.fwd_data%0d", i), fwd_data[i*XLEN +: XLEN], ed);
    end
    lu = 0;
    if (id_ex_valid && id_ex_mem_read && id_ex_rd != 0)
      for (int i = 0; i < NUM_SRC; i++)
        if (if_id_rs_used[i] && if_id_rs[i*RA_W +: RA_W] == id_ex_rd) lu = 1;
    hold = 0; done = 0; busy = (m_left > 0);
    if (flush)                n_left <= 0;
    else if (m_left == 0) begin
      if (id_ex_valid && id_ex_multicycle) begin hold = 1; n_left <= MC_LAT - 1; end
      else n_left <= 0;
    end else if (m_left == 1) begin done = 1; n_left <= 0; end
    else begin hold = 1; n_left <= m_left - 1; end
    lus = lu && !hold && !flush;
    n_lu <= (lus && m_lu < CMAX) ? m_lu + 1 : m_lu;
    n_mc <= (hold && m_mc < CMAX) ? m_mc + 1 : m_mc;
    rr = reset;
    chk("m.pc_hold",       64'(pc_hold),       64'(rr && (hold || lus)));
    chk("m.if_id_hold",    64'(if_id_hold),    64'(rr && (hold || lus)));
    chk("m.id_ex_hold",    64'(id_ex_hold),    64'(rr && hold));
    chk("m.ex_mem_bubble", 64'(ex_mem_bubble), 64'(rr && hold));
    chk("m.id_ex_bubble",  64'(id_ex_bubble),  64'(rr && (flush || lus)));
    chk("m.mc_busy",       64'(mc_busy),       64'(rr && busy));
    chk("m.mc_done",       64'(mc_done),       64'(rr && done));
    chk("m.cnt_load_use",  64'(cnt_load_use),  64'(m_lu));
    chk("m.cnt_mc_stall",  64'(cnt_mc_stall),  64'(m_mc));
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin m_left <= 0; m_lu <= 0; m_mc <= 0; end
    else begin m_left <= n_left; m_lu <= n_lu; m_mc <= n_mc; end
  end

  // ---------------- stimulus ----------------
  task automatic clr();
    id_ex_rs = '0; id_ex_rdata = '0; id_ex_valid = 0; id_ex_mem_read = 0; id_ex_rd = '0;
    id_ex_multicycle = 0; if_id_rs = '0; if_id_rs_used = '0;
    ex_mem_regwrite = 0; ex_mem_rd = '0; ex_mem_alu_result = '0;
    mem_wb_regwrite = 0; mem_wb_mem_to_reg = 0; mem_wb_rd = '0;
    mem_wb_alu_result = '0; mem_wb_read_data = '0; flush = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    clr();
    // reset window: control forced low, forwarding still live
    flush = 1; ex_mem_regwrite = 1; ex_mem_rd = 5'd4; ex_mem_alu_result = 64'hAB;
    id_ex_rs = {5'd0, 5'd4};
    @(negedge clk);
    chk("rst.id_ex_bubble", 64'(id_ex_bubble), 64'd0);
    chk("rst.pc_hold",      64'(pc_hold),      64'd0);
    chk("rst.fwd_sel0",     64'(fwd_sel[1:0]), 64'h2);
    chk("rst.cnt_lu",       64'(cnt_load_use), 64'd0);
    step(); reset = 1'b1; clr();

    // EX/MEM beats MEM/WB on both operands
    ex_mem_regwrite = 1; ex_mem_rd = 5'd5; ex_mem_alu_result = 64'hA5A5;
    mem_wb_regwrite = 1; mem_wb_rd = 5'd5; mem_wb_alu_result = 64'h77;
    id_ex_rs = {5'd5, 5'd5};
    @(negedge clk);
    chk("t1.fwd_sel",   64'(fwd_sel), 64'hA);
    chk("t1.fwd_data0", fwd_data[63:0],   64'hA5A5);
    chk("t1.fwd_data1", fwd_data[127:64], 64'hA5A5);

    // MEM/WB load forwards read data
    step(); clr();
    mem_wb_regwrite = 1; mem_wb_mem_to_reg = 1; mem_wb_rd = 5'd7;
    mem_wb_read_data = 64'hDEAD; mem_wb_alu_result = 64'hBEEF;
    ex_mem_regwrite = 1; ex_mem_rd = 5'd9;
    id_ex_rs = {5'd7, 5'd2}; id_ex_rdata = {64'h2000, 64'h1000};
    @(negedge clk);
    chk("t2.fwd_sel1",  64'(fwd_sel[3:2]),  64'h1);
    chk("t2.fwd_data1", fwd_data[127:64],   64'hDEAD);
    chk("t2.fwd_sel0",  64'(fwd_sel[1:0]),  64'h0);
    chk("t2.fwd_data0", fwd_data[63:0],     64'h1000);
    step(); mem_wb_rd = 5'd0; id_ex_rs = {5'd0, 5'd2};
    @(negedge clk);
    chk("t2.x0_sel1",  64'(fwd_sel[3:2]), 64'h0);
    chk("t2.x0_data1", fwd_data[127:64],  64'h2000);

    // load-use stall, then bubble in EX clears it
    step(); clr();
    id_ex_valid = 1; id_ex_mem_read = 1; id_ex_rd = 5'd3;
    if_id_rs = {5'd0, 5'd3}; if_id_rs_used = 2'b01;
    @(negedge clk);
    chk("t3.pc_hold",    64'(pc_hold),      64'd1);
    chk("t3.if_id_hold", 64'(if_id_hold),   64'd1);
    chk("t3.bubble",     64'(id_ex_bubble), 64'd1);
    chk("t3.id_ex_hold", 64'(id_ex_hold),   64'd0);
    step(); id_ex_valid = 0;
    @(negedge clk);
    chk("t3.cleared",    64'(pc_hold),      64'd0);
    chk("t3.cnt_lu",     64'(cnt_load_use), 64'd1);
    step(); id_ex_valid = 1; if_id_rs_used = 2'b10;
    @(negedge clk);
    chk("t3.unused_hold", 64'(pc_hold), 64'd0);
    step(); clr();
    @(negedge clk);
    chk("t3.cnt_lu_keep", 64'(cnt_load_use), 64'd1);

    // multi-cycle op: 3 holds, done on 4th, busy on 2-4
    step(); id_ex_valid = 1; id_ex_multicycle = 1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      @(negedge clk);
      chk($sformatf("t4.pc_hold%0d", k),  64'(pc_hold),       64'(k < 3));
      chk($sformatf("t4.exm_bub%0d", k),  64'(ex_mem_bubble), 64'(k < 3));
      chk($sformatf("t4.done%0d", k),     64'(mc_done),       64'(k == 3));
      chk($sformatf("t4.busy%0d", k),     64'(mc_busy),       64'(k > 0));
    end
    step(); clr();
    @(negedge clk);
    chk("t4.cnt_mc", 64'(cnt_mc_stall), 64'd3);
    chk("t4.idle",   64'(mc_busy),      64'd0);

    // flush during the second hold cycle
    step(); id_ex_valid = 1; id_ex_multicycle = 1;
    @(negedge clk);
    chk("t5.hold1", 64'(pc_hold), 64'd1);
    step(); flush = 1;
    @(negedge clk);
    chk("t5.pc_hold",    64'(pc_hold),      64'd0);
    chk("t5.id_ex_hold", 64'(id_ex_hold),   64'd0);
    chk("t5.bubble",     64'(id_ex_bubble), 64'd1);
    chk("t5.done",       64'(mc_done),      64'd0);
    step(); clr();
    @(negedge clk);
    chk("t5.busy_after", 64'(mc_busy),      64'd0);
    chk("t5.done_after", 64'(mc_done),      64'd0);
    chk("t5.cnt_mc",     64'(cnt_mc_stall), 64'd4);

    // async reset while busy, then a clean op
    step(); id_ex_valid = 1; id_ex_multicycle = 1;
    step();
    chk("t6.busy_pre", 64'(mc_busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("t6.rst_hold", 64'(pc_hold),      64'd0);
    chk("t6.rst_busy", 64'(mc_busy),      64'd0);
    chk("t6.rst_cnt",  64'(cnt_mc_stall), 64'd0);
    step(); reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      @(negedge clk);
      chk($sformatf("t6.hold%0d", k), 64'(id_ex_hold), 64'(k < 3));
      chk($sformatf("t6.done%0d", k), 64'(mc_done),    64'(k == 3));
    end
    step(); clr();
    @(negedge clk);
    chk("t6.cnt_mc", 64'(cnt_mc_stall), 64'd3);

    // random traffic against the model; counters saturate along the way
    for (int n = 0; n < 2000; n++) begin
      step();
      for (int i = 0; i < NUM_SRC; i++) begin
        id_ex_rs[i*RA_W +: RA_W]    = RA_W'($urandom_range(0, 7));
        if_id_rs[i*RA_W +: RA_W]    = RA_W'($urandom_range(0, 7));
        id_ex_rdata[i*XLEN +: XLEN] = {$urandom(), $urandom()};
      end
      if_id_rs_used     = NUM_SRC'($urandom());
      id_ex_valid       = ($urandom_range(0, 3) != 0);
      id_ex_mem_read    = $urandom_range(0, 1) == 1;
      id_ex_rd          = RA_W'($urandom_range(0, 7));
      id_ex_multicycle  = ($urandom_range(0, 7) == 0);
      ex_mem_regwrite   = $urandom_range(0, 1) == 1;
      ex_mem_rd         = RA_W'($urandom_range(0, 7));
      ex_mem_alu_result = {$urandom(), $urandom()};
      mem_wb_regwrite   = $urandom_range(0, 1) == 1;
      mem_wb_mem_to_reg = $urandom_range(0, 1) == 1;
      mem_wb_rd         = RA_W'($urandom_range(0, 7));
      mem_wb_alu_result = {$urandom(), $urandom()};
      mem_wb_read_data  = {$urandom(), $urandom()};
      flush             = ($urandom_range(0, 15) == 0);
    end
    step(); clr();
    @(negedge clk);
    chk("sat.cnt_lu", 64'(cnt_load_use), 64'hF);
    chk("sat.cnt_mc", 64'(cnt_mc_stall), 64'hF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ex_fwd_hazard_unit.md
Name: ex_fwd_hazard_unit

Overview:
Parametrised execute-stage forwarding and hazard controller for the 5-stage pipeline. It resolves operand forwarding for NUM_SRC source operands from EX/MEM and MEM/WB; the MEM/WB path is load-aware and selects memory read data for loads. It detects load-use hazards and generates a one-cycle bubble. It sequences multi-cycle EX operations (mul/div) with a busy FSM, and keeps saturating stall counters.

Parameters:
XLEN, 64, datapath width
RA_W, 5, register address width
NUM_SRC, 2, source operands per instruction (1..3)
MC_LAT, 4, EX cycles for a multi-cycle op (>=2)
CNT_W, 32, stall counter width

Ports:
clk  input  1  clock, rising edge
reset  input  1  reset, asynchronous, active-low
id_ex_rs  input  NUM_SRC*RA_W  source regs of instr in EX; operand i at [i*RA_W +: RA_W]
id_ex_rdata  input  NUM_SRC*XLEN  register-file read data for EX operands
id_ex_valid  input  1  EX holds a real instruction
id_ex_mem_read  input  1  EX instr is a load
id_ex_rd  input  RA_W  EX destination
id_ex_multicycle  input  1  EX instr needs MC_LAT cycles
if_id_rs  input  NUM_SRC*RA_W  source regs of instr in ID
if_id_rs_used  input  NUM_SRC  per-operand use flag in ID
ex_mem_regwrite  input  1  EX/MEM writes a register
ex_mem_rd  input  RA_W  EX/MEM destination
ex_mem_alu_result  input  XLEN  EX/MEM ALU result
mem_wb_regwrite  input  1  MEM/WB writes a register
mem_wb_mem_to_reg  input  1  MEM/WB is a load
mem_wb_rd  input  RA_W  MEM/WB destination
mem_wb_alu_result  input  XLEN  MEM/WB ALU result
mem_wb_read_data  input  XLEN  MEM/WB memory read data
flush  input  1  pipeline flush from MEM (mispredict/trap)
fwd_sel  output  NUM_SRC*2  per-operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
fwd_data  output  NUM_SRC*XLEN  forwarded operand values
pc_hold  output  1  freeze PC
if_id_hold  output  1  freeze IF/ID
id_ex_hold  output  1  freeze ID/EX (multi-cycle in progress)
id_ex_bubble  output  1  load NOP into ID/EX
ex_mem_bubble  output  1  load NOP into EX/MEM
mc_busy  output  1  FSM in MC_BUSY
mc_done  output  1  last EX cycle of a multi-cycle op
cnt_load_use  output  CNT_W  load-use stall cycles
cnt_mc_stall  output  CNT_W  multi-cycle hold cycles

Behaviour:
- Forwarding, combinational, per operand i:
  - EX/MEM match (ex_mem_regwrite, ex_mem_rd!=0, ex_mem_rd==rs[i]) -> sel 10, data ex_mem_alu_result.
  - Otherwise MEM/WB match (same rule) -> sel 01, data mem_wb_mem_to_reg ? mem_wb_read_data : mem_wb_alu_result.
  - Otherwise sel 00, data id_ex_rdata[i].
  - EX/MEM has priority over MEM/WB. x0 is never forwarded.
- Load-use (lu), combinational:
  - lu = id_ex_valid & id_ex_mem_read & id_ex_rd!=0 & OR_i(if_id_rs_used[i] & if_id_rs[i]==id_ex_rd).
  - While lu and no mc hold: pc_hold=1, if_id_hold=1, id_ex_bubble=1 for exactly one cycle. The bubble clears lu on the next cycle.
- FSM states RUN, MC_BUSY; 3-bit-min down-counter cnt sized for MC_LAT-2.
  - RUN: if id_ex_valid & id_ex_multicycle & !flush, then mc_hold=1 this cycle and next state is MC_BUSY with cnt=MC_LAT-2.
  - MC_BUSY: cnt!=0 -> mc_hold=1, cnt-1. cnt==0 -> mc_hold=0, mc_done=1, next state RUN.
  - The op occupies EX for exactly MC_LAT cycles, with MC_LAT-1 hold cycles and one mc_done pulse.
  - mc_hold drives pc_hold, if_id_hold, id_ex_hold and ex_mem_bubble, all =1. It suppresses id_ex_bubble; lu is re-evaluated once the hold drops.
  - flush in any state: all holds are 0 that cycle, id_ex_bubble=1, next state RUN, cnt=0, no mc_done.
  - Back-to-back multi-cycle ops: after mc_done the next op enters EX and restarts from RUN.
- Counters:
  - cnt_load_use increments each lu stall cycle.
  - cnt_mc_stall increments each mc_hold cycle.
  - Both saturate at all-ones.
- Reset (reset=0, asynchronous): state RUN, cnt=0, both counters 0.
  - All hold/bubble outputs, mc_busy and mc_done are 0 while reset is asserted.
  - fwd_sel=00 is not forced; it follows its inputs.
  - Reset mid-op discards the op.

Decomposition:
- Package ex_fwd_pkg holds: FWD_REG=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01; the state enum (RUN, MC_BUSY); and default XLEN/RA_W.
- Sub-module fwd_operand_mux does the compare and mux for one operand. It is instantiated NUM_SRC times in a generate loop.

Test Plan:
- ex_mem rd=5 regwrite=1 with id_ex_rs0=5 rs1=5, and mem_wb rd=5 also matching -> fwd_sel=10/10, fwd_data=ex_mem_alu_result for both operands.
- mem_wb rd=7, mem_to_reg=1, read_data=0xDEAD, rs1=7, no EX/MEM match -> fwd_sel[1]=01, fwd_data[1]=0xDEAD. With rd=0 instead -> sel 00.
- Load in EX rd=3, ID rs0=3 used -> one cycle of pc_hold/if_id_hold/id_ex_bubble. Same pattern with if_id_rs_used[0]=0 -> no stall. cnt_load_use=1.
- Multi-cycle op, MC_LAT=4 -> holds high for 3 cycles, mc_done on the 4th, mc_busy high for cycles 2-4, cnt_mc_stall=3.
- flush in the 2nd hold cycle -> holds drop immediately, id_ex_bubble=1, no mc_done, FSM back in RUN.
- reset asserted in MC_BUSY -> outputs 0 asynchronously. After release, a multi-cycle op completes in 4 cycles again.
